com_sync_fifo_flex: RTL and testbench

COM_SYNC_FIFO_FLEX -- requirements
Module: com_sync_fifo_flex

---
 rtl/com_fifo_pkg.sv | 13 +
 rtl/com_fifo_ptr.sv | 56 +++++
 rtl/com_sync_fifo_flex.sv | 179 +++++++++++++++++
 tb/tb_com_sync_fifo_flex.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/com_fifo_pkg.sv
// Shared constants and helpers for the com_* FIFO family.
package com_fifo_pkg;

    // Read-latency encodings for the RD_LAT parameter.
    localparam int RD_SHOWAHEAD = 0;
    localparam int RD_REG       = 1;

    // Width needed to hold a count from 0 up to and including depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : com_fifo_pkg

// File: rtl/com_fifo_ptr.sv
// One wrap-and-phase FIFO pointer: an index in 0..DEPTH-1 plus a phase bit
// that toggles on every wrap, so equal indices can be told apart as full/empty.
module com_fifo_ptr #(
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [IW-1:0] idx_o,
    output logic          phase_o,
    output logic [IW-1:0] idx_nxt_o,
    output logic          phase_nxt_o
);

    logic [IW-1:0] idx_q, idx_d;
    logic          phase_q, phase_d;

    // Next pointer: clear wins, otherwise advance and wrap at DEPTH-1.
    // NOTE: defaults first so every path assigns idx_d/phase_d; this keeps the
    // block purely combinational (blocking '=') with no inferred latch.
    always_comb begin
        idx_d   = idx_q;
        phase_d = phase_q;
        if (clr_i) begin
            idx_d   = '0;
            phase_d = 1'b0;
        end else if (inc_i) begin
            if (idx_q == IW'(DEPTH - 1)) begin
                idx_d   = '0;
                phase_d = ~phase_q;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Pointer state register.
    // NOTE: state registers use non-blocking '<=' so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

    assign idx_o       = idx_q;
    assign phase_o     = phase_q;
    assign idx_nxt_o   = idx_d;
    assign phase_nxt_o = phase_d;

endmodule : com_fifo_ptr

// File: rtl/com_sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, selectable show-ahead or registered
// read, registered status flags/counts and sticky overflow/underflow flags.
module com_sync_fifo_flex
    import com_fifo_pkg::*;
#(
    parameter int DW     = 8,
    parameter int DEPTH  = 4,
    parameter int RD_LAT = RD_SHOWAHEAD,
    parameter int AF_LVL = DEPTH - 1,
    parameter int AE_LVL = 1,
    parameter int CW     = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          wr_full,
    output logic          wr_afull,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_empty,
    output logic          rd_aempty,
    output logic [CW-1:0] used_cnt,
    output logic [CW-1:0] free_cnt,
    output logic          ovf,
    output logic          udf
);

    localparam int IW = $clog2(DEPTH);

    if (DEPTH < 2) begin : g_chk_depth
        $error("com_sync_fifo_flex: DEPTH must be at least 2");
    end
    if (AF_LVL > DEPTH) begin : g_chk_af
        $error("com_sync_fifo_flex: AF_LVL must not exceed DEPTH");
    end
    if (AE_LVL >= DEPTH) begin : g_chk_ae
        $error("com_sync_fifo_flex: AE_LVL must be below DEPTH");
    end
    if (RD_LAT != RD_SHOWAHEAD && RD_LAT != RD_REG) begin : g_chk_lat
        $error("com_sync_fifo_flex: RD_LAT must be 0 or 1");
    end

    logic [DW-1:0] mem_q [DEPTH];

    logic [IW-1:0] widx, widx_nxt, ridx, ridx_nxt;
    logic          wph, wph_nxt, rph, rph_nxt;
    logic          wr_acc, rd_acc;

    logic          full_q, empty_q, afull_q, aempty_q, ovf_q, udf_q;
    logic          full_d, empty_d, afull_d, aempty_d, ovf_d, udf_d;
    logic [CW-1:0] used_q, used_d, free_q, free_d;

    // Accept decisions use the flags as they stand before this edge.
    assign wr_acc = wr_en && !full_q  && !clear;
    assign rd_acc = rd_en && !empty_q && !clear;

    com_fifo_ptr #(.DEPTH(DEPTH), .IW(IW)) u_wr_ptr (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clear),
        .inc_i       (wr_acc),
        .idx_o       (widx),
        .phase_o     (wph),
        .idx_nxt_o   (widx_nxt),
        .phase_nxt_o (wph_nxt)
    );

    com_fifo_ptr #(.DEPTH(DEPTH), .IW(IW)) u_rd_ptr (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clear),
        .inc_i       (rd_acc),
        .idx_o       (ridx),
        .phase_o     (rph),
        .idx_nxt_o   (ridx_nxt),
        .phase_nxt_o (rph_nxt)
    );

    // Storage write at the write pointer.
    // NOTE: the array has no reset so it maps onto plain RAM; stale entries are
    // never visible because the empty flag and pointers gate every read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[widx] <= wr_data;
        end
    end

    // Next-state status, computed from post-edge pointers and counts so the
    // registered flags carry no lag cycle.
    always_comb begin
        used_d = used_q;
        if (clear) begin
            used_d = '0;
        end else if (wr_acc && !rd_acc) begin
            used_d = used_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            used_d = used_q - 1'b1;
        end

        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clear) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            if (wr_en && full_q) ovf_d = 1'b1;
            if (rd_en && empty_q) udf_d = 1'b1;
        end

        full_d   = (widx_nxt == ridx_nxt) && (wph_nxt != rph_nxt);
        empty_d  = (widx_nxt == ridx_nxt) && (wph_nxt == rph_nxt);
        free_d   = CW'(DEPTH) - used_d;
        afull_d  = (used_d >= CW'(AF_LVL));
        aempty_d = (used_d <= CW'(AE_LVL));
    end

    // Status register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= (AF_LVL == 0);
            aempty_q <= 1'b1;
            used_q   <= '0;
            free_q   <= CW'(DEPTH);
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            used_q   <= used_d;
            free_q   <= free_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    if (RD_LAT == RD_SHOWAHEAD) begin : g_showahead
        assign rd_data  = empty_q ? '0 : mem_q[ridx];
        assign rd_valid = ~empty_q;
    end else begin : g_registered
        logic [DW-1:0] rd_data_q;
        logic          rd_valid_q;

        // Registered read: capture the head on an accepted read, hold otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (clear) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= mem_q[ridx];
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

    assign wr_full   = full_q;
    assign wr_afull  = afull_q;
    assign rd_empty  = empty_q;
    assign rd_aempty = aempty_q;
    assign used_cnt  = used_q;
    assign free_cnt  = free_q;
    assign ovf       = ovf_q;
    assign udf       = udf_q;

endmodule : com_sync_fifo_flex

// File: tb/tb_com_sync_fifo_flex.sv
// Bench for com_sync_fifo_flex: one show-ahead and one registered-read instance
// share stimulus and are compared every cycle against a queue-based model.
module tb_com_sync_fifo_flex;

    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;

    logic          d0_full, d0_afull, d0_valid, d0_empty, d0_aempty, d0_ovf, d0_udf;
    logic [DW-1:0] d0_data;
    logic [CW-1:0] d0_used, d0_free;
    logic          d1_full, d1_afull, d1_valid, d1_empty, d1_aempty, d1_ovf, d1_udf;
    logic [DW-1:0] d1_data;
    logic [CW-1:0] d1_used, d1_free;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state.
    logic [DW-1:0] mq[$];
    logic          m_ovf, m_udf, m_l1_valid;
    logic [DW-1:0] m_l1_data;

    always #5 clk = ~clk;

    com_sync_fifo_flex #(.DW(DW), .DEPTH(DEPTH), .RD_LAT(0), .AF_LVL(4), .AE_LVL(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(d0_full), .wr_afull(d0_afull),
        .rd_en(rd_en), .rd_data(d0_data), .rd_valid(d0_valid), .rd_empty(d0_empty),
        .rd_aempty(d0_aempty), .used_cnt(d0_used), .free_cnt(d0_free),
        .ovf(d0_ovf), .udf(d0_udf)
    );

    com_sync_fifo_flex #(.DW(DW), .DEPTH(DEPTH), .RD_LAT(1), .AF_LVL(4), .AE_LVL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(d1_full), .wr_afull(d1_afull),
        .rd_en(rd_en), .rd_data(d1_data), .rd_valid(d1_valid), .rd_empty(d1_empty),
        .rd_aempty(d1_aempty), .used_cnt(d1_used), .free_cnt(d1_free),
        .ovf(d1_ovf), .udf(d1_udf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
        m_l1_valid = 1'b0;
        m_l1_data  = '0;
    endtask

    // One clock edge of FIFO behaviour, from the pre-edge contents.
    task automatic model_step(input logic we, input logic [DW-1:0] wd,
                              input logic re, input logic clr);
        int n;
        bit wacc, racc;
        n = mq.size();
        if (clr) begin
            model_reset();
        end else begin
            wacc = we && (n < DEPTH);
            racc = re && (n > 0);
            if (we && n == DEPTH) m_ovf = 1'b1;
            if (re && n == 0)     m_udf = 1'b1;
            m_l1_valid = racc;
            if (racc) begin
                m_l1_data = mq[0];
                void'(mq.pop_front());
            end
            if (wacc) mq.push_back(wd);
        end
    endtask

    // Full comparison of both instances against the model.
    task automatic compare_all();
        int u;
        logic [DW-1:0] head;
        u    = mq.size();
        head = (u == 0) ? '0 : mq[0];
        check("used0",   32'(d0_used),   32'(u));
        check("used1",   32'(d1_used),   32'(u));
        check("free0",   32'(d0_free),   32'(DEPTH - u));
        check("free1",   32'(d1_free),   32'(DEPTH - u));
        check("full0",   32'(d0_full),   32'(u == DEPTH));
        check("full1",   32'(d1_full),   32'(u == DEPTH));
        check("empty0",  32'(d0_empty),  32'(u == 0));
        check("empty1",  32'(d1_empty),  32'(u == 0));
        check("afull0",  32'(d0_afull),  32'(u >= 4));
        check("afull1",  32'(d1_afull),  32'(u >= 4));
        check("aempty0", 32'(d0_aempty), 32'(u <= 1));
        check("aempty1", 32'(d1_aempty), 32'(u <= 1));
        check("ovf0",    32'(d0_ovf),    32'(m_ovf));
        check("ovf1",    32'(d1_ovf),    32'(m_ovf));
        check("udf0",    32'(d0_udf),    32'(m_udf));
        check("udf1",    32'(d1_udf),    32'(m_udf));
        check("rdata0",  32'(d0_data),   32'(head));
        check("rvalid0", 32'(d0_valid),  32'(u != 0));
        check("rdata1",  32'(d1_data),   32'(m_l1_data));
        check("rvalid1", 32'(d1_valid),  32'(m_l1_valid));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare at negedge.
    task automatic cycle(input logic we, input logic [DW-1:0] wd,
                         input logic re, input logic clr);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        clear   = clr;
        @(posedge clk);
        model_step(we, wd, re, clr);
        @(negedge clk);
        compare_all();
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] v;
        rst_n   = 1'b0;
        clear   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        model_reset();

        // Reset state.
        #12;
        compare_all();
        check("rst_used", 32'(d0_used), 32'd0);
        check("rst_free", 32'(d1_free), 32'd5);
        check("rst_aempty", 32'(d1_aempty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 0x01..0x05, then a sixth write while full.
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, DW'(i), 1'b0, 1'b0);
            if (i == 4) begin
                check("afull_at4", 32'(d0_afull), 32'd1);
                check("full_at4",  32'(d0_full),  32'd0);
            end
        end
        check("full_at5", 32'(d1_full), 32'd1);
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        check("ovf_6th",   32'(d0_ovf),  32'd1);
        check("head_kept", 32'(d0_data), 32'h01);

        // Concurrent write and read while full: only the read is taken.
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        check("fullrw_data", 32'(d1_data),  32'h01);
        check("fullrw_used", 32'(d1_used),  32'd4);
        check("fullrw_head", 32'(d0_data),  32'h02);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("drain_last", 32'(d1_data), 32'h05);
        check("drain_empty", 32'(d0_empty), 32'd1);

        // Concurrent write and read while empty: only the write is taken.
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 8'h11, 1'b1, 1'b0);
        check("emptyrw_used",  32'(d0_used),  32'd1);
        check("emptyrw_udf",   32'(d0_udf),   32'd1);
        check("emptyrw_valid", 32'(d1_valid), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("emptyrw_data", 32'(d1_data), 32'h11);

        // Wrap: four rounds of three writes then three reads.
        v = 8'h40;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) begin
                cycle(1'b1, v, 1'b0, 1'b0);
                v = v + 8'h1;
            end
            for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        end
        check("wrap_last",  32'(d1_data),  32'h4B);
        check("wrap_empty", 32'(d0_empty), 32'd1);

        // Registered-read latency.
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        check("lat_none", 32'(d1_valid), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("lat_data",  32'(d1_data),  32'hA5);
        check("lat_valid", 32'(d1_valid), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("lat_drop", 32'(d1_valid), 32'd0);
        check("lat_hold", 32'(d1_data),  32'hA5);

        // Clear at used 3 with udf set.
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("udf_set", 32'(d1_udf), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h90 + i), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("clr_used",  32'(d0_used),  32'd0);
        check("clr_free",  32'(d0_free),  32'd5);
        check("clr_udf",   32'(d0_udf),   32'd0);
        check("clr_data1", 32'(d1_data),  32'd0);
        check("clr_data0", 32'(d0_data),  32'd0);

        // Reset pulsed mid-burst.
        cycle(1'b1, 8'h21, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        wr_en   = 1'b1;
        wr_data = 8'h23;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("arst_used",  32'(d0_used),  32'd0);
        check("arst_empty", 32'(d1_empty), 32'd1);
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        check("post_head", 32'(d0_data), 32'h3C);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("post_data", 32'(d1_data), 32'h3C);
        check("post_empty", 32'(d0_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_com_sync_fifo_flex
